// File: rtl/ofm_writeback_ctrl.sv
// Sequences PE reset/finish per OFM pixel and packs full PE beats into 32-bit BRAM writes.
// Writes start the cycle after capture; no backpressure -- beats arriving with both pack entries full are dropped (sticky overflow).
module ofm_writeback_ctrl #(
   parameter int NUM_PE        = 16,
   parameter int CYC_PER_PIXEL = 36,
   parameter int NUM_PIXELS    = 3136,
   parameter int START_DELAY   = 3,
   parameter int ADDR_W        = 32,
   localparam int GRP = NUM_PE / 4,
   localparam int CMW = (GRP > 1) ? $clog2(GRP) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cal_start,
   input  logic [ADDR_W-1:0]   base_addr,
   input  logic [NUM_PE-1:0]   valid,
   input  logic [8*NUM_PE-1:0] ofm_in,
   output logic [NUM_PE-1:0]   PE_reset,
   output logic [NUM_PE-1:0]   PE_finish,
   output logic                wr_en_next,
   output logic [ADDR_W-1:0]   addr_ram_next_wr,
   output logic [31:0]         data_next,
   output logic [CMW-1:0]      control_mux,
   output logic                busy,
   output logic                done,
   output logic                overflow
);
   localparam int PW = $clog2(CYC_PER_PIXEL);
   localparam int XW = $clog2(NUM_PIXELS + 1);
   localparam int DW = (START_DELAY > 0) ? $clog2(START_DELAY + 1) : 1;

   typedef enum logic [2:0] {S_IDLE, S_DELAY, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t              state;
   logic [DW-1:0]       dly_cnt;
   logic [PW-1:0]       phase;
   logic [XW-1:0]       pix;
   logic [XW-1:0]       beat_cnt;
   logic [8*NUM_PE-1:0] pbuf [2];
   logic [1:0]          full, full_n;
   logic                rp, wp;
   logic [CMW-1:0]      grp;
   logic [ADDR_W-1:0]   nxt_addr;

   logic                start, active, acc, last, free_wp, cap, drop, bypass, head_vld;
   logic [8*NUM_PE-1:0] head_dat;
   logic [31:0]         head_word;

   assign start    = (state == S_IDLE) && cal_start;
   assign active   = (state == S_DELAY) || (state == S_RUN) || (state == S_DRAIN);
   assign acc      = active && (&valid);
   assign last     = (grp == CMW'(GRP - 1));
   // The entry on its final drain group is released in time to take a new beat.
   assign free_wp  = !full[wp] || (full[rp] && (rp == wp) && last);
   assign cap      = acc && free_wp;
   assign drop     = acc && !free_wp;
   // With an empty buffer the incoming beat drains straight away.
   assign bypass   = !full[rp] && cap;
   assign head_vld = full[rp] || cap;
   assign head_dat = full[rp] ? pbuf[rp] : ofm_in;

   always_comb begin
      head_word = '0;
      for (int j = 0; j < 4; j++)
         head_word[8*(3-j) +: 8] = head_dat[8*(4*int'(grp)+j) +: 8];
   end

   always_comb begin
      full_n = full;
      if (full[rp] && last) full_n[rp] = 1'b0;
      if (cap && !(bypass && last)) full_n[wp] = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pbuf[0]          <= '0;
         pbuf[1]          <= '0;
         full             <= '0;
         rp               <= 1'b0;
         wp               <= 1'b0;
         grp              <= '0;
         beat_cnt         <= '0;
         nxt_addr         <= '0;
         overflow         <= 1'b0;
         wr_en_next       <= 1'b0;
         addr_ram_next_wr <= '0;
         data_next        <= '0;
         control_mux      <= '0;
      end else begin
         full       <= full_n;
         wr_en_next <= head_vld;
         if (cap) begin
            pbuf[wp] <= ofm_in;
            wp       <= ~wp;
         end
         if (drop) overflow <= 1'b1;
         if (start)
            beat_cnt <= '0;
         else if (acc && (beat_cnt != XW'(NUM_PIXELS)))
            beat_cnt <= beat_cnt + XW'(1);
         if (start)
            nxt_addr <= base_addr;
         else if (head_vld)
            nxt_addr <= nxt_addr + ADDR_W'(1);
         if (head_vld) begin
            addr_ram_next_wr <= nxt_addr;
            data_next        <= head_word;
            control_mux      <= grp;
            if (last) begin
               grp <= '0;
               rp  <= ~rp;
            end else begin
               grp <= grp + CMW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         dly_cnt   <= '0;
         phase     <= '0;
         pix       <= '0;
         PE_reset  <= '0;
         PE_finish <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (cal_start) begin
                  state   <= S_DELAY;
                  dly_cnt <= '0;
                  busy    <= 1'b1;
               end
            end
            S_DELAY: begin
               if (dly_cnt == DW'(START_DELAY)) begin
                  state    <= S_RUN;
                  phase    <= '0;
                  pix      <= '0;
                  PE_reset <= '1;
               end else begin
                  dly_cnt <= dly_cnt + DW'(1);
               end
            end
            S_RUN: begin
               if (phase == PW'(CYC_PER_PIXEL - 1)) begin
                  PE_finish <= '0;
                  if (pix == XW'(NUM_PIXELS - 1)) begin
                     state <= S_DRAIN;
                  end else begin
                     phase    <= '0;
                     pix      <= pix + XW'(1);
                     PE_reset <= '1;
                  end
               end else begin
                  phase     <= phase + PW'(1);
                  PE_reset  <= '0;
                  PE_finish <= {NUM_PE{phase == PW'(CYC_PER_PIXEL - 2)}};
               end
            end
            S_DRAIN: begin
               if ((beat_cnt == XW'(NUM_PIXELS)) && (full == 2'b00) && !cap) begin
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            S_DONE: begin
               if (!cal_start) begin
                  state <= S_IDLE;
                  done  <= 1'b0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ofm_writeback_ctrl.sv
// Scoreboard bench: an 8-PE instance for sequencing/packing/reset and a 16-PE instance for overflow.
module tb_ofm_writeback_ctrl;
   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [1:0]  cm;
   } wr_t;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         cal_start = 1'b0;
   logic [31:0]  base_addr = '0;
   logic [7:0]   valid8 = '0;
   logic [63:0]  ofm8 = '0;
   logic [15:0]  valid16 = '0;
   logic [127:0] ofm16 = '0;

   logic [7:0]   pr8, pf8;
   logic         wr8, busy8, done8, ovf8;
   logic [31:0]  a8, dat8;
   logic [0:0]   cm8;
   logic [15:0]  pr16, pf16;
   logic         wr16, busy16, done16, ovf16;
   logic [31:0]  a16, dat16;
   logic [1:0]   cm16;

   int           n_cmp = 0;
   int           n_bad = 0;
   wr_t          q8[$];
   wr_t          q16[$];
   wr_t          m8, m16;
   logic [31:0]  ea8, ea16;
   logic [127:0] beat;

   always #5 clk = ~clk;

   ofm_writeback_ctrl #(.NUM_PE(8), .CYC_PER_PIXEL(6), .NUM_PIXELS(3), .START_DELAY(3), .ADDR_W(32)) d8 (
      .clk(clk), .reset(reset), .cal_start(cal_start), .base_addr(base_addr),
      .valid(valid8), .ofm_in(ofm8), .PE_reset(pr8), .PE_finish(pf8),
      .wr_en_next(wr8), .addr_ram_next_wr(a8), .data_next(dat8), .control_mux(cm8),
      .busy(busy8), .done(done8), .overflow(ovf8));

   ofm_writeback_ctrl #(.NUM_PE(16), .CYC_PER_PIXEL(6), .NUM_PIXELS(3), .START_DELAY(3), .ADDR_W(32)) d16 (
      .clk(clk), .reset(reset), .cal_start(cal_start), .base_addr(base_addr),
      .valid(valid16), .ofm_in(ofm16), .PE_reset(pr16), .PE_finish(pf16),
      .wr_en_next(wr16), .addr_ram_next_wr(a16), .data_next(dat16), .control_mux(cm16),
      .busy(busy16), .done(done16), .overflow(ovf16));

   function automatic logic [7:0] bval(input int n, input int k, input int off);
      return 8'(n * 16 + k + off);
   endfunction

   function automatic logic [127:0] mk_beat(input int n, input int npe, input int off);
      logic [127:0] v;
      v = '0;
      for (int k = 0; k < npe; k++) v[8*k +: 8] = bval(n, k, off);
      return v;
   endfunction

   function automatic logic [31:0] exp_word(input int n, input int g, input int off);
      return {bval(n, 4*g, off), bval(n, 4*g+1, off), bval(n, 4*g+2, off), bval(n, 4*g+3, off)};
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic push_wr8(input logic [31:0] addr, input logic [31:0] data, input int g);
      wr_t e;
      e.addr = addr;
      e.data = data;
      e.cm   = 2'(g);
      q8.push_back(e);
   endtask

   task automatic push8(input int n);
      for (int g = 0; g < 2; g++) begin
         push_wr8(ea8, exp_word(n, g, 1), g);
         ea8 = ea8 + 32'd1;
      end
   endtask

   task automatic push16(input int n);
      wr_t e;
      for (int g = 0; g < 4; g++) begin
         e.addr = ea16;
         e.data = exp_word(n, g, 0);
         e.cm   = 2'(g);
         q16.push_back(e);
         ea16 = ea16 + 32'd1;
      end
   endtask

   task automatic zero_chk(input string tag);
      chk({tag, "_wr"},    64'(wr8),   64'd0);
      chk({tag, "_addr"},  64'(a8),    64'd0);
      chk({tag, "_data"},  64'(dat8),  64'd0);
      chk({tag, "_cm"},    64'(cm8),   64'd0);
      chk({tag, "_pers"},  64'(pr8),   64'd0);
      chk({tag, "_pefin"}, 64'(pf8),   64'd0);
      chk({tag, "_busy"},  64'(busy8), 64'd0);
      chk({tag, "_done"},  64'(done8), 64'd0);
      chk({tag, "_ovf"},   64'(ovf8),  64'd0);
      chk({tag, "_d16"}, 64'({wr16, a16, cm16, pr16, pf16, busy16, done16, ovf16}), 64'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      valid8 = '0;
      valid16 = '0;
      cal_start = 1'b0;
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic wait_done8(input string tag);
      int i;
      i = 0;
      while (!done8 && i < 100) begin
         @(negedge clk);
         i++;
      end
      chk({tag, "_done"}, 64'(done8), 64'd1);
   endtask

   task automatic wait_done16(input string tag);
      int i;
      i = 0;
      while (!done16 && i < 100) begin
         @(negedge clk);
         i++;
      end
      chk({tag, "_done16"}, 64'(done16), 64'd1);
   endtask

   always @(negedge clk) begin
      if (wr8) begin
         if (q8.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL w8_unexpected: got write addr 0x%0h data 0x%0h, expected no write", a8, dat8);
         end else begin
            m8 = q8.pop_front();
            chk("w8_addr_data", {a8, dat8}, {m8.addr, m8.data});
            chk("w8_cm", 64'(cm8), 64'(m8.cm));
         end
      end
   end

   always @(negedge clk) begin
      if (wr16) begin
         if (q16.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL w16_unexpected: got write addr 0x%0h data 0x%0h, expected no write", a16, dat16);
         end else begin
            m16 = q16.pop_front();
            chk("w16_addr_data", {a16, dat16}, {m16.addr, m16.data});
            chk("w16_cm", 64'(cm16), 64'(m16.cm));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      #12;
      zero_chk("rst");

      // Layer A: sequencing, first pack, partial valid, late third beat
      do_reset();
      base_addr = 32'h100;
      ea8 = 32'h100;
      cal_start = 1'b1;
      for (int k = 0; k <= 24; k++) begin
         @(posedge clk);
         #1;
         case (k)
            0: cal_start = 1'b0;
            5: begin
               valid8 = 8'hFF;
               beat = mk_beat(0, 8, 1);
               ofm8 = beat[63:0];
               push_wr8(32'h100, 32'h01020304, 0);
               push_wr8(32'h101, 32'h05060708, 1);
               ea8 = 32'h102;
            end
            6: begin
               valid8 = 8'h7F;
               ofm8 = 64'h9999_9999_9999_9999;
            end
            7: valid8 = 8'h00;
            11: begin
               valid8 = 8'hFF;
               beat = mk_beat(1, 8, 1);
               ofm8 = beat[63:0];
               push8(1);
            end
            12: valid8 = 8'h00;
            default: ;
         endcase
         @(negedge clk);
         chk($sformatf("seq_pe_reset_e%0d", k), 64'(pr8),
             (k == 4 || k == 10 || k == 16) ? 64'hFF : 64'h0);
         chk($sformatf("seq_pe_finish_e%0d", k), 64'(pf8),
             (k == 9 || k == 15 || k == 21) ? 64'hFF : 64'h0);
      end
      chk("A_done_early", 64'(done8), 64'd0);
      chk("A_busy", 64'(busy8), 64'd1);
      @(posedge clk);
      #1;
      valid8 = 8'hFF;
      beat = mk_beat(2, 8, 1);
      ofm8 = beat[63:0];
      push8(2);
      @(posedge clk);
      #1 valid8 = 8'h00;
      wait_done8("A");
      chk("A_ovf", 64'(ovf8), 64'd0);

      // Layer B: three back-to-back beats, contiguous writes, done then back to idle
      do_reset();
      base_addr = 32'h200;
      ea8 = 32'h200;
      cal_start = 1'b1;
      @(posedge clk);
      #1 cal_start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      for (int n = 0; n < 3; n++) begin
         valid8 = 8'hFF;
         beat = mk_beat(n, 8, 1);
         ofm8 = beat[63:0];
         push8(n);
         @(posedge clk);
         #1;
      end
      valid8 = 8'h00;
      wait_done8("B");
      chk("B_busy", 64'(busy8), 64'd0);
      chk("B_ovf", 64'(ovf8), 64'd0);
      chk("B_all_written", 64'(q8.size()), 64'd0);
      @(posedge clk);
      @(negedge clk);
      chk("B_done_clear", 64'(done8), 64'd0);

      // Layer C: 16-PE instance, four back-to-back beats, third one dropped
      do_reset();
      base_addr = 32'h300;
      ea16 = 32'h300;
      cal_start = 1'b1;
      @(posedge clk);
      #1 cal_start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      for (int n = 1; n <= 4; n++) begin
         valid16 = 16'hFFFF;
         beat = mk_beat(n, 16, 0);
         ofm16 = beat;
         if (n != 3) push16(n);
         @(posedge clk);
         #1;
         if (n == 2) chk("C_ovf_before", 64'(ovf16), 64'd0);
         if (n == 3) chk("C_ovf_set", 64'(ovf16), 64'd1);
      end
      valid16 = 16'h0000;
      wait_done16("C");
      chk("C_ovf_sticky", 64'(ovf16), 64'd1);
      chk("C_ovf8_clean", 64'(ovf8), 64'd0);

      // Layer D: reset during a drain, then restart from a new base
      do_reset();
      base_addr = 32'h400;
      ea8 = 32'h400;
      cal_start = 1'b1;
      @(posedge clk);
      #1 cal_start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      valid8 = 8'hFF;
      beat = mk_beat(0, 8, 1);
      ofm8 = beat[63:0];
      push_wr8(32'h400, exp_word(0, 0, 1), 0);
      @(posedge clk);
      #1 valid8 = 8'h00;
      @(negedge clk);
      #2 reset = 1'b1;
      #1 zero_chk("D_midrst");
      @(posedge clk);
      #1 reset = 1'b0;
      base_addr = 32'h500;
      ea8 = 32'h500;
      cal_start = 1'b1;
      @(posedge clk);
      #1 cal_start = 1'b0;
      chk("D_busy", 64'(busy8), 64'd1);
      repeat (5) @(posedge clk);
      #1;
      valid8 = 8'hFF;
      beat = mk_beat(1, 8, 1);
      ofm8 = beat[63:0];
      push8(1);
      @(posedge clk);
      #1 valid8 = 8'h00;
      repeat (4) @(negedge clk);
      chk("q8_drained", 64'(q8.size()), 64'd0);
      chk("q16_drained", 64'(q16.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
